// File: rtl/rom_browser.sv
// ROM inspection front-end: debounced inc/dec buttons step an address, the word is fetched and shown as {addr, data}.
// Latency: step pulse to o_valid high is ROM_LAT + 2 cycles; buttons add 2 sync cycles plus DEBOUNCE_CYC.
// Backpressure: one step may be held pending while a fetch is in flight; further steps during that fetch are dropped.
module rom_browser #(
  parameter int ADDR_W           = 12,
  parameter int DATA_W           = 8,
  parameter int ROM_LAT          = 1,
  parameter int DISPLAYS         = 4,
  parameter int DEBOUNCE_CYC     = 270_000,
  parameter int REPEAT_DELAY_CYC = 13_500_000,
  parameter int REPEAT_RATE_CYC  = 2_700_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_button_inc,
  input  logic                    i_button_dec,
  input  logic [DATA_W-1:0]       i_rom_data,
  output logic [ADDR_W-1:0]       o_rom_addr,
  output logic                    o_rom_ce,
  output logic [ADDR_W-1:0]       o_addr,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  output logic [4*DISPLAYS-1:0]   o_hex
);

  localparam int HEX_W = 4 * DISPLAYS;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RP_W  = $clog2(REPEAT_DELAY_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY_CYC);
  // After a repeat hit the timer restarts so that it hits again REPEAT_RATE_CYC later.
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1);
  localparam logic [2:0]      LAT_LAST  = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0] btn_raw;
  logic [1:0] db_lvl;
  logic [1:0] btn_rise;
  logic [1:0] rpt_hit;
  logic       both_held;

  assign btn_raw   = {i_button_dec, i_button_inc};
  assign both_held = &db_lvl;

  // Per-button synchroniser, debouncer and hold-to-repeat timer.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rep_q, rep_d;

    // Debounce: the level flips only after the synchronised input has differed for DEBOUNCE_CYC cycles.
    always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Repeat timer tracks cycles since the debounced press; cleared on release or when both are held.
    always_comb begin
      rep_d = rep_q;
      if (!db_q || both_held) begin
        rep_d = '0;
      end else if (rep_q == RP_DELAY) begin
        rep_d = RP_RELOAD;
      end else begin
        rep_d = rep_q + RP_W'(1);
      end
    end

    // Button state registers.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_q      <= 1'b0;
        db_prev_q <= 1'b0;
        db_cnt_q  <= '0;
        rep_q     <= '0;
      end else begin
        sync1_q   <= btn_raw[b];
        sync2_q   <= sync1_q;
        db_q      <= db_d;
        db_prev_q <= db_q;
        db_cnt_q  <= db_cnt_d;
        rep_q     <= rep_d;
      end
    end

    assign db_lvl[b]   = db_q;
    assign btn_rise[b] = db_q & ~db_prev_q;
    assign rpt_hit[b]  = db_q & (rep_q == RP_DELAY);
  end

  logic step_inc, step_dec, step_any;

  // A button only steps while the other one is released.
  assign step_inc = (btn_rise[0] | rpt_hit[0]) & ~db_lvl[1];
  assign step_dec = (btn_rise[1] | rpt_hit[1]) & ~db_lvl[0];
  assign step_any = step_inc | step_dec;

  state_t              state_q;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                pend_vld_q, pend_dir_q;
  logic [2:0]          lat_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                rom_ce_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic [HEX_W-1:0]    hex_q;
  logic                apply_dec;
  logic                pend_take;

  // A pending step takes precedence over a fresh one; direction 1 means decrement.
  assign apply_dec = pend_vld_q ? pend_dir_q : step_dec;
  assign target_d  = apply_dec ? (target_q - ADDR_W'(1)) : (target_q + ADDR_W'(1));
  assign pend_take = step_any & ~pend_vld_q & (state_q != S_SHOW);

  // Fetch sequencer with registered outputs; address and target stay frozen until the word is captured.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_BOOT;
      target_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= 1'b0;
      lat_q      <= '0;
      rom_addr_q <= '0;
      rom_ce_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      hex_q      <= '0;
    end else begin
      if (pend_take) begin
        pend_vld_q <= 1'b1;
        pend_dir_q <= step_dec;
      end
      case (state_q)
        S_BOOT: begin
          target_q   <= '0;
          rom_addr_q <= '0;
          rom_ce_q   <= 1'b1;
          valid_q    <= 1'b0;
          state_q    <= S_FETCH;
        end
        S_FETCH: begin
          lat_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            data_q   <= i_rom_data;
            addr_q   <= target_q;
            hex_q    <= HEX_W'({target_q, i_rom_data});
            valid_q  <= 1'b1;
            rom_ce_q <= 1'b0;
            state_q  <= S_SHOW;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        S_SHOW: begin
          if (pend_vld_q || step_any) begin
            target_q   <= target_d;
            rom_addr_q <= target_d;
            rom_ce_q   <= 1'b1;
            valid_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_rom_ce   = rom_ce_q;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_hex      = hex_q;

endmodule

// File: tb/tb_rom_browser.sv
// Bench for rom_browser: two instances (short and long ROM latency) against a ROM model and an address model.
// Address model counts expected step pulses per hold length from the debounce/repeat timing rules.
// Per-cycle monitor checks shown data, hex packing, ce/valid exclusivity and address stability during fetches.
module tb_rom_browser;

  localparam int DEB1 = 4,  DLY1 = 20, RATE1 = 5, LAT1 = 2;
  localparam int DEB2 = 2,  DLY2 = 3,  RATE2 = 3, LAT2 = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc1, dec1, inc2, dec2;
  logic [7:0]  rom_data1, rom_data2;
  logic [11:0] rom_addr1, rom_addr2, addr1, addr2;
  logic        rom_ce1, rom_ce2, valid1, valid2;
  logic [7:0]  data1, data2;
  logic [15:0] hex1, hex2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rom_browser #(.ADDR_W(12), .DATA_W(8), .ROM_LAT(LAT1), .DISPLAYS(4), .DEBOUNCE_CYC(DEB1),
                .REPEAT_DELAY_CYC(DLY1), .REPEAT_RATE_CYC(RATE1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button_inc(inc1), .i_button_dec(dec1),
    .i_rom_data(rom_data1), .o_rom_addr(rom_addr1), .o_rom_ce(rom_ce1),
    .o_addr(addr1), .o_data(data1), .o_valid(valid1), .o_hex(hex1));

  rom_browser #(.ADDR_W(12), .DATA_W(8), .ROM_LAT(LAT2), .DISPLAYS(4), .DEBOUNCE_CYC(DEB2),
                .REPEAT_DELAY_CYC(DLY2), .REPEAT_RATE_CYC(RATE2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button_inc(inc2), .i_button_dec(dec2),
    .i_rom_data(rom_data2), .o_rom_addr(rom_addr2), .o_rom_ce(rom_ce2),
    .o_addr(addr2), .o_data(data2), .o_valid(valid2), .o_hex(hex2));

  function automatic logic [7:0] romf(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [15:0] hexf(input logic [11:0] a, input logic [7:0] d);
    logic [19:0] pk;
    pk = {a, d};
    return pk[15:0];
  endfunction

  // Pulses from a clean press of h cycles: none if shorter than the debounce window, else one
  // at press offset 0 plus one at each offset dly + k*rate that still lies inside the hold.
  function automatic int npulses(input int h, input int deb, input int dly, input int rate);
    if (h < deb) return 0;
    if (h - 1 < dly) return 1;
    return 2 + (h - 1 - dly) / rate;
  endfunction

  // Synchronous ROMs of fixed latency, clocked only while ce is high.
  logic [7:0] pipe1 [LAT1];
  logic [7:0] pipe2 [LAT2];
  always @(posedge clk) if (rom_ce1) begin
    pipe1[0] <= romf(rom_addr1);
    for (int k = 1; k < LAT1; k++) pipe1[k] <= pipe1[k-1];
  end
  always @(posedge clk) if (rom_ce2) begin
    pipe2[0] <= romf(rom_addr2);
    for (int k = 1; k < LAT2; k++) pipe2[k] <= pipe2[k-1];
  end
  assign rom_data1 = pipe1[LAT1-1];
  assign rom_data2 = pipe2[LAT2-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  logic        prev_ce1 = 1'b0, prev_ce2 = 1'b0;
  logic [11:0] prev_ra1 = '0, prev_ra2 = '0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (valid1) begin
        chk("mon_data1", data1, romf(addr1));
        chk("mon_hex1", hex1, hexf(addr1, data1));
        chk("mon_ce_off1", rom_ce1, 1'b0);
      end
      if (rom_ce1 && prev_ce1) chk("mon_addr_hold1", rom_addr1, prev_ra1);
      if (valid2) begin
        chk("mon_data2", data2, romf(addr2));
        chk("mon_hex2", hex2, hexf(addr2, data2));
        chk("mon_ce_off2", rom_ce2, 1'b0);
      end
      if (rom_ce2 && prev_ce2) chk("mon_addr_hold2", rom_addr2, prev_ra2);
    end
    prev_ce1 = rom_ce1; prev_ra1 = rom_addr1;
    prev_ce2 = rom_ce2; prev_ra2 = rom_addr2;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press1(input bit dec, input int h);
    if (dec) dec1 = 1'b1; else inc1 = 1'b1;
    cyc(h);
    inc1 = 1'b0;
    dec1 = 1'b0;
  endtask

  task automatic wait_valid(input bit second, input string nm);
    int n = 0;
    while (((second ? valid2 : valid1) !== 1'b1) && n < 100) begin
      cyc(1);
      n++;
    end
    chk(nm, second ? valid2 : valid1, 1'b1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, valid1, 1'b0);
    chk({nm, "_ce"}, rom_ce1, 1'b0);
    chk({nm, "_romaddr"}, rom_addr1, 12'h000);
    chk({nm, "_addr"}, addr1, 12'h000);
    chk({nm, "_data"}, data1, 8'h00);
    chk({nm, "_hex"}, hex1, 16'h0000);
  endtask

  task automatic boot_seq(input string nm);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_valid_edge%0d", nm, i), valid1, (i == 4));
    end
    cyc(1);
    chk({nm, "_addr"}, addr1, 12'h000);
    chk({nm, "_data"}, data1, 8'h5A);
    chk({nm, "_hex"}, hex1, 16'h005A);
  endtask

  logic [11:0] exp_a;
  int          htab [5] = '{3, 4, 20, 21, 26};

  initial begin
    rst_n = 1'b0;
    inc1 = 1'b0; dec1 = 1'b0; inc2 = 1'b0; dec2 = 1'b0;
    cyc(5);
    chk_zero("reset");
    chk("reset_valid2", valid2, 1'b0);
    chk("reset_hex2", hex2, 16'h0000);
    mon_en = 1'b1;

    // Boot: valid on the 4th edge after reset release, address 0.
    rst_n = 1'b1;
    boot_seq("boot");
    wait_valid(1'b1, "boot2_valid");
    exp_a = 12'h000;

    // Bouncy press then a 10-cycle hold: exactly one step.
    inc1 = 1'b1; cyc(1); inc1 = 1'b0; cyc(1); inc1 = 1'b1; cyc(10); inc1 = 1'b0;
    cyc(30);
    chk("bounce_addr", addr1, 12'h001);
    chk("bounce_data", data1, 8'h5B);

    // Wrap-around in both directions.
    press1(1'b1, 6); cyc(30);
    chk("dec_to_zero", addr1, 12'h000);
    press1(1'b1, 6); cyc(30);
    chk("wrap_dec_addr", addr1, 12'hFFF);
    chk("wrap_dec_data", data1, 8'hA5);
    press1(1'b0, 6); cyc(30);
    chk("wrap_inc_addr", addr1, 12'h000);

    // Hold 40 cycles: steps at offsets 0,20,25,30,35.
    press1(1'b0, 40); cyc(30);
    chk("repeat_addr", addr1, 12'h005);
    exp_a = 12'h005;

    // Boundary hold lengths around debounce and repeat thresholds.
    foreach (htab[i]) begin
      press1(1'b0, htab[i]); cyc(30);
      exp_a = exp_a + 12'(npulses(htab[i], DEB1, DLY1, RATE1));
      chk($sformatf("edge_hold%0d", htab[i]), addr1, exp_a);
    end

    // Randomised presses in either direction.
    for (int it = 0; it < 16; it++) begin
      bit dec;
      int h;
      dec = 1'($urandom_range(0, 1));
      h   = $urandom_range(1, 32);
      press1(dec, h); cyc(30);
      if (dec) exp_a = exp_a - 12'(npulses(h, DEB1, DLY1, RATE1));
      else     exp_a = exp_a + 12'(npulses(h, DEB1, DLY1, RATE1));
      chk($sformatf("rand%0d_addr", it), addr1, exp_a);
      chk($sformatf("rand%0d_valid", it), valid1, 1'b1);
    end

    // Reset during WAIT abandons the fetch; refetch address 0 after release.
    begin
      int n = 0;
      inc1 = 1'b1;
      while (rom_ce1 !== 1'b1 && n < 40) begin cyc(1); n++; end
      chk("rst_fetch_started", rom_ce1, 1'b1);
      cyc(1);
      rst_n = 1'b0;
      inc1 = 1'b0;
      cyc(1);
      chk_zero("midrst");
      cyc(3);
      rst_n = 1'b1;
      boot_seq("reboot");
    end

    // Long-latency instance: pulses at 0,3,6 of an 8-cycle hold; the 3 is held pending, the 6 dropped.
    wait_valid(1'b1, "u2_reboot_valid");
    chk("u2_start_addr", addr2, 12'h000);
    inc2 = 1'b1; cyc(8); inc2 = 1'b0;
    cyc(40);
    chk("pend_addr", addr2, 12'h002);
    chk("pend_data", data2, 8'h58);
    inc2 = 1'b1; cyc(2); inc2 = 1'b0;
    cyc(40);
    chk("pend_single_addr", addr2, 12'h003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
